// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: N-digit BCD up/down counter with wrap/saturate, fire edge detect, load/clear, status flags
// Ports: clk, reset (async, active-high); enable gates steps; fire = count request; dir 0=up 1=down;
//        clear/load synchronous (clear > load > step); load_val packed BCD (digits >9 clamp to 9);
//        count packed BCD (digit 0 at [3:0]); zero/at_max decode count; wrap_pulse one cycle after a wrap;
//        ovf_sticky latches any wrap or limit hit until reset/clear.
module bcd_updown_counter #(
  parameter int DIGITS    = 3,
  parameter bit SATURATE  = 1'b0,
  parameter bit EDGE_FIRE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fire,
  input  logic                  dir,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  at_max,
  output logic                  wrap_pulse,
  output logic                  ovf_sticky
);
  logic [4*DIGITS-1:0] count_q, count_d, nxt, clamp;
  logic                fire_q, fire_d, wrap_q, wrap_d, ovf_q, ovf_d;
  logic                c, all9, step, hit;
  logic [3:0]          d, ld;
  always_comb begin
    nxt   = count_q;
    clamp = load_val;
    c     = 1'b1;
    all9  = 1'b1;
    d     = '0;
    ld    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d  = count_q[4*i +: 4];
      ld = load_val[4*i +: 4];
      clamp[4*i +: 4] = ld > 4'd9 ? 4'd9 : ld;
      nxt[4*i +: 4]   = !c ? d : dir ? (d == 4'd0 ? 4'd9 : d - 4'd1) : (d == 4'd9 ? 4'd0 : d + 4'd1);
      c    = c & (dir ? d == 4'd0 : d == 4'd9);
      all9 = all9 & (d == 4'd9);
    end
    // carry/borrow out of the top digit means the step runs past the limit
    step    = enable & (EDGE_FIRE ? fire & ~fire_q : fire);
    hit     = step & c & ~load & ~clear;
    count_d = clear ? '0 : load ? clamp : (step & ~(SATURATE & c)) ? nxt : count_q;
    wrap_d  = hit & ~SATURATE;
    ovf_d   = ~clear & (ovf_q | hit);
    fire_d  = fire;
  end
  // fire_q resets to 1 so a fire held high across reset release is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      fire_q  <= 1'b1;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      fire_q  <= fire_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end
  assign count      = count_q;
  assign zero       = count_q == '0;
  assign at_max     = all9;
  assign wrap_pulse = wrap_q;
  assign ovf_sticky = ovf_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed scoreboard bench for bcd_updown_counter across four configurations
module tb_bcd_updown_counter;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, fire = 1'b0, dir = 1'b0, clear = 1'b0, load = 1'b0;
  logic [11:0] load_val = '0;
  logic [19:0] load_val5 = '0;
  logic [11:0] cnt_w, cnt_s, cnt_e;
  logic [19:0] cnt_5;
  logic [3:0]  f_w, f_s, f_e, f_5;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    string       tag;
    int          sel;
    logic [23:0] v;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  bcd_updown_counter #(.DIGITS(3), .SATURATE(1'b0), .EDGE_FIRE(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .fire(fire), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val), .count(cnt_w), .zero(f_w[3]), .at_max(f_w[2]), .wrap_pulse(f_w[1]), .ovf_sticky(f_w[0]));
  bcd_updown_counter #(.DIGITS(3), .SATURATE(1'b1), .EDGE_FIRE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .fire(fire), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val), .count(cnt_s), .zero(f_s[3]), .at_max(f_s[2]), .wrap_pulse(f_s[1]), .ovf_sticky(f_s[0]));
  bcd_updown_counter #(.DIGITS(3), .SATURATE(1'b0), .EDGE_FIRE(1'b0)) u_lvl (
    .clk(clk), .reset(reset), .enable(enable), .fire(fire), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val), .count(cnt_e), .zero(f_e[3]), .at_max(f_e[2]), .wrap_pulse(f_e[1]), .ovf_sticky(f_e[0]));
  bcd_updown_counter #(.DIGITS(5), .SATURATE(1'b0), .EDGE_FIRE(1'b1)) u_d5 (
    .clk(clk), .reset(reset), .enable(enable), .fire(fire), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val5), .count(cnt_5), .zero(f_5[3]), .at_max(f_5[2]), .wrap_pulse(f_5[1]), .ovf_sticky(f_5[0]));
  function automatic logic [23:0] obs(input int sel);
    return sel == 0 ? {8'h0, cnt_w, f_w} : sel == 1 ? {8'h0, cnt_s, f_s} :
           sel == 2 ? {8'h0, cnt_e, f_e} : {cnt_5, f_5};
  endfunction
  // f = {zero, at_max, wrap_pulse, ovf_sticky}
  task automatic push(input string tag, input int sel, input logic [19:0] cnt, input logic [3:0] f);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.v   = {cnt, f};
    q.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    logic [23:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sel);
      n_cmp++;
      assert (o === e.v) else begin
        n_err++;
        $error("FAIL %s: got cnt=%h flags=%b, want cnt=%h flags=%b", e.tag, o[23:4], o[3:0], e.v[23:4], e.v[3:0]);
      end
    end
  endtask
  task automatic tk();
    @(posedge clk);
    #1;
    drain();
  endtask
  initial begin
    #2;
    push("reset_w", 0, 20'h0, 4'b1000);
    push("reset_5", 3, 20'h0, 4'b1000);
    drain();
    @(posedge clk);
    #1 reset = 1'b0;
    // wrap up
    load = 1'b1; load_val = 12'h998;
    push("load998", 0, 20'h998, 4'b0000); tk();
    load = 1'b0; fire = 1'b1;
    push("up999", 0, 20'h999, 4'b0100); tk();
    fire = 1'b0;
    push("hold999", 0, 20'h999, 4'b0100); tk();
    fire = 1'b1;
    push("wrap000", 0, 20'h000, 4'b1011); tk();
    fire = 1'b0;
    push("wrap_fall", 0, 20'h000, 4'b1001); tk();
    push("sticky_hold", 0, 20'h000, 4'b1001); tk();
    clear = 1'b1;
    push("clear", 0, 20'h000, 4'b1000); tk();
    clear = 1'b0;
    // borrow / down
    load = 1'b1; load_val = 12'h100; dir = 1'b1;
    push("load100", 0, 20'h100, 4'b0000); tk();
    load = 1'b0; fire = 1'b1;
    push("down099", 0, 20'h099, 4'b0000); tk();
    fire = 1'b0; load = 1'b1; load_val = 12'h000;
    push("load000", 0, 20'h000, 4'b1000); tk();
    load = 1'b0; fire = 1'b1;
    push("under999", 0, 20'h999, 4'b0111); tk();
    fire = 1'b0;
    push("under_fall", 0, 20'h999, 4'b0101); tk();
    fire = 1'b1;
    push("down998", 0, 20'h998, 4'b0001); tk();
    fire = 1'b0; dir = 1'b0;
    push("dir_idle", 0, 20'h998, 4'b0001); tk();
    fire = 1'b1;
    push("dir_up999", 0, 20'h999, 4'b0101); tk();
    fire = 1'b0; clear = 1'b1;
    push("clear2", 0, 20'h000, 4'b1000); tk();
    clear = 1'b0;
    // edge qualification: held fire counts once
    fire = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push("held_fire", 0, 20'h001, 4'b0000); tk();
    end
    fire = 1'b0;
    push("held_release", 0, 20'h001, 4'b0000); tk();
    enable = 1'b0; fire = 1'b1;
    push("edge_disabled", 0, 20'h001, 4'b0000); tk();
    enable = 1'b1;
    push("edge_lost", 0, 20'h001, 4'b0000); tk();
    fire = 1'b0;
    push("edge_low", 0, 20'h001, 4'b0000); tk();
    fire = 1'b1;
    push("edge_new", 0, 20'h002, 4'b0000); tk();
    fire = 1'b0;
    // priority / clamp
    load = 1'b1; load_val = 12'h9A3;
    push("clamp993", 0, 20'h993, 4'b0000); tk();
    load_val = 12'h999;
    push("load999", 0, 20'h999, 4'b0100); tk();
    load = 1'b0; fire = 1'b1;
    push("wrap_again", 0, 20'h000, 4'b1011); tk();
    fire = 1'b0; clear = 1'b1; load = 1'b1; load_val = 12'h250;
    push("clear_load", 0, 20'h000, 4'b1000); tk();
    clear = 1'b0; fire = 1'b1;
    push("load_over_step", 0, 20'h250, 4'b0000); tk();
    load = 1'b0; fire = 1'b0;
    push("load_hold", 0, 20'h250, 4'b0000); tk();
    // async reset mid-cycle, with sticky set and fire held across release
    load = 1'b1; load_val = 12'h999;
    push("pre_load999", 0, 20'h999, 4'b0100); tk();
    load = 1'b0; fire = 1'b1;
    push("pre_wrap", 0, 20'h000, 4'b1011); tk();
    fire = 1'b0; load = 1'b1; load_val = 12'h457;
    push("load457_keeps_ovf", 0, 20'h457, 4'b0001); tk();
    load = 1'b0;
    #2 reset = 1'b1; fire = 1'b1;
    #1;
    push("async_reset", 0, 20'h000, 4'b1000);
    drain();
    @(posedge clk);
    #1 reset = 1'b0;
    push("fire_held_rel", 0, 20'h000, 4'b1000); tk();
    push("fire_held_rel2", 0, 20'h000, 4'b1000); tk();
    fire = 1'b0;
    push("fire_low", 0, 20'h000, 4'b1000); tk();
    fire = 1'b1;
    push("fire_after_rst", 0, 20'h001, 4'b0000); tk();
    fire = 1'b0;
    // saturate instance
    load = 1'b1; load_val = 12'h999;
    push("sat_load999", 1, 20'h999, 4'b0100); tk();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fire = 1'b1;
      push("sat_up_hold", 1, 20'h999, 4'b0101); tk();
      fire = 1'b0;
      push("sat_up_idle", 1, 20'h999, 4'b0101); tk();
    end
    clear = 1'b1;
    push("sat_clear", 1, 20'h000, 4'b1000); tk();
    clear = 1'b0; dir = 1'b1; fire = 1'b1;
    push("sat_down_hold", 1, 20'h000, 4'b1001); tk();
    fire = 1'b0;
    push("sat_down_idle", 1, 20'h000, 4'b1001); tk();
    dir = 1'b0;
    // level fire instance
    clear = 1'b1;
    push("lvl_clear", 2, 20'h000, 4'b1000); tk();
    clear = 1'b0; fire = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      push("lvl_count", 2, i < 10 ? 20'(i) : 20'h010, 4'b0000); tk();
    end
    fire = 1'b0;
    push("lvl_stop", 2, 20'h010, 4'b0000); tk();
    // five-digit wrap
    load = 1'b1; load_val5 = 20'h99999;
    push("d5_load", 3, 20'h99999, 4'b0100); tk();
    load = 1'b0; fire = 1'b1;
    push("d5_wrap", 3, 20'h00000, 4'b1011); tk();
    fire = 1'b0;
    push("d5_fall", 3, 20'h00000, 4'b1001); tk();
    load = 1'b1; load_val5 = 20'hF0B1C;
    push("d5_clamp", 3, 20'h90919, 4'b0001); tk();
    load = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
